// File: rtl/riscv_membus_router_if.sv
// Native picorv32-style memory bus. NUM_PORTS widens valid/ready/rdata so the
// same interface serves both the single CPU port and the fanned-out slave side.
// master drives the request; slave returns rdata/ready.
interface riscv_membus_router_if #(
  parameter int unsigned NUM_PORTS = 1
);
  logic [NUM_PORTS-1:0]    valid;
  logic                    instr;
  logic [31:0]             addr;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic [32*NUM_PORTS-1:0] rdata;
  logic [NUM_PORTS-1:0]    ready;

  modport master (output valid, instr, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, instr, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/riscv_membus_router.sv
// riscv_membus_router: routes picorv32 native-bus requests to NUM_SLAVES targets
// decoded by base/mask (lowest index wins on overlap). Unmapped accesses, and
// stalled accesses when MEMBUS_TIMEOUT_EN is defined, complete with ERR_RDATA and
// a bus_err pulse so the CPU never hangs.
// Optional feature macro: MEMBUS_TIMEOUT_EN (slave wait timeout, TIMEOUT_CYCLES).
module riscv_membus_router #(
  parameter int unsigned                NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_BASE     = {32'h0010_0000, 32'h0002_0000,
                                                          32'h0001_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK     = {32'hFFF0_0000, 32'hFFFF_0000,
                                                          32'hFFFF_0000, 32'hFFF0_0000},
  parameter int unsigned                TIMEOUT_CYCLES = 256,
  parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  riscv_membus_router_if.slave  m,
  riscv_membus_router_if.master s,
  output logic                  bus_err,
  output logic [31:0]           err_addr
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP, ERR} state_t;

  state_t                 state;
  logic [SEL_W-1:0]       sel;

  logic                   hit;
  logic [SEL_W-1:0]       hit_idx;
  logic [NUM_SLAVES-1:0]  hit_onehot;
  logic                   sel_ready;
  logic [31:0]            sel_rdata;
  logic                   timeout;

`ifdef MEMBUS_TIMEOUT_EN
  localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 8)  ? 8 :
                                      (CNT_W_RAW > 16) ? 16 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout = (wait_cnt == WAIT_LAST);
`else
  // No wait counter in this build: ACTIVE waits for the slave indefinitely and
  // TIMEOUT_CYCLES has no effect.
  assign timeout = 1'b0;
  if (TIMEOUT_CYCLES != 0) begin : g_no_timeout
  end
`endif

  // Address decode: scan from the top so the lowest-index hit is the one left standing.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((m.addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit           = 1'b1;
        hit_idx       = SEL_W'(i);
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
      end
    end
  end

  // Only the latched slave's ready and read data are ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ready = s.ready[i];
        sel_rdata = s.rdata[i*32 +: 32];
      end
    end
  end

  // Transaction FSM; every bus-facing output is a register set on the transition.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      sel      <= '0;
      s.valid  <= '0;
      s.instr  <= 1'b0;
      s.addr   <= '0;
      s.wdata  <= '0;
      s.wstrb  <= '0;
      m.ready  <= 1'b0;
      m.rdata  <= '0;
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (m.valid[0]) begin
            s.instr <= m.instr;
            s.addr  <= m.addr;
            s.wdata <= m.wdata;
            s.wstrb <= m.wstrb;
            if (hit) begin
              sel     <= hit_idx;
              s.valid <= hit_onehot;
              state   <= ACTIVE;
            end else begin
              state   <= ERR;
            end
          end
        end
        ACTIVE: begin
          // A ready arriving in the expiry cycle still wins over the timeout.
          if (sel_ready) begin
            m.rdata <= sel_rdata;
            s.valid <= '0;
            m.ready <= 1'b1;
            state   <= RESP;
          end else if (timeout) begin
            s.valid <= '0;
            state   <= ERR;
          end
        end
        ERR: begin
          // The request is dropped; the CPU sees the error word and a one-cycle pulse.
          m.ready  <= 1'b1;
          bus_err  <= 1'b1;
          m.rdata  <= ERR_RDATA;
          err_addr <= s.addr;
          state    <= RESP;
        end
        RESP: begin
          m.ready <= 1'b0;
          bus_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEMBUS_TIMEOUT_EN
  // Count ACTIVE cycles that pass without a ready from the selected slave.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (state != ACTIVE) begin
      wait_cnt <= '0;
    end else if (!sel_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_membus_router.sv
// Bench for riscv_membus_router: table of single transactions with expected
// select/latency/response, a scoreboard checked whenever m_ready pulses, and
// hand-written sequences for decode overlap and mid-transaction reset.
// Timeout vectors are added when MEMBUS_TIMEOUT_EN is defined.
module tb_riscv_membus_router;

  logic        clk = 1'b0;
  logic        resetn;
  logic        bus_err, def_bus_err;
  logic [31:0] err_addr, def_err_addr;

  always #5 clk = ~clk;

  riscv_membus_router_if #(.NUM_PORTS(1)) cpu ();
  riscv_membus_router_if #(.NUM_PORTS(4)) slv ();
  riscv_membus_router_if #(.NUM_PORTS(1)) def_cpu ();
  riscv_membus_router_if #(.NUM_PORTS(4)) def_slv ();

  // Slave 0 narrowed to 64 KiB so slaves 1 and 2 are reachable on their own.
  riscv_membus_router #(
    .NUM_SLAVES     (4),
    .SLAVE_BASE     ({32'h0010_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_0000}),
    .SLAVE_MASK     ({32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) u_dut (
    .clk      (clk),
    .resetn   (resetn),
    .m        (cpu),
    .s        (slv),
    .bus_err  (bus_err),
    .err_addr (err_addr)
  );

  // Default map: slave 0 (0x000x_xxxx) overlaps slaves 1 and 2, so slave 0 must win.
  riscv_membus_router u_dut_def (
    .clk      (clk),
    .resetn   (resetn),
    .m        (def_cpu),
    .s        (def_slv),
    .bus_err  (def_bus_err),
    .err_addr (def_err_addr)
  );

  assign def_cpu.valid = cpu.valid;
  assign def_cpu.instr = cpu.instr;
  assign def_cpu.addr  = cpu.addr;
  assign def_cpu.wdata = cpu.wdata;
  assign def_cpu.wstrb = cpu.wstrb;
  assign def_slv.ready = slv.ready;
  assign def_slv.rdata = slv.rdata;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    bit          hold_valid;
    int          waits;
    logic [31:0] srdata;
    logic [3:0]  exp_onehot;
    int          exp_sv_cycles;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] err_addr;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_err_addr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic instr, input bit hold_valid,
                              input int waits, input logic [31:0] srdata, input logic [3:0] onehot,
                              input int sv_cycles, input bit err, input logic [31:0] rdata,
                              input int lat);
    vec_t v;
    v.name = name;   v.addr = addr;   v.wdata = wdata; v.wstrb = wstrb;
    v.instr = instr; v.hold_valid = hold_valid; v.waits = waits; v.srdata = srdata;
    v.exp_onehot = onehot; v.exp_sv_cycles = sv_cycles; v.exp_err = err;
    v.exp_rdata = rdata;   v.exp_lat = lat;
    return v;
  endfunction

  // Selected slave answers after v.waits cycles; every other slave asserts ready
  // permanently with inverted data, which the router must ignore.
  task automatic drive_slaves(input vec_t v, input int c);
    slv.ready = ~v.exp_onehot | ((c == v.waits + 1) ? v.exp_onehot : 4'b0000);
    for (int j = 0; j < 4; j++)
      slv.rdata[j*32 +: 32] = v.exp_onehot[j] ? v.srdata : ~v.srdata;
  endtask

  task automatic run_vec(input vec_t v);
    int       lat;
    bit       seen;
    logic [3:0] sv_exp;
    @(posedge clk); #1;
    cpu.valid = 1'b1;
    cpu.instr = v.instr;
    cpu.addr  = v.addr;
    cpu.wdata = v.wdata;
    cpu.wstrb = v.wstrb;
    drive_slaves(v, 0);
    if (v.exp_err) last_err_addr = v.addr;
    sb_q.push_back('{v.name, v.exp_rdata, v.exp_err, last_err_addr});
    seen = 1'b0;
    lat  = -1;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (!v.hold_valid) cpu.valid = 1'b0;
        drive_slaves(v, c);
      end
      @(negedge clk);
      sv_exp = (c >= 1 && c <= v.exp_sv_cycles) ? v.exp_onehot : 4'b0000;
      check({v.name, " s_valid"}, 32'(slv.valid), 32'(sv_exp));
      if (sv_exp != 4'b0000) begin
        check({v.name, " s_addr"},  slv.addr, v.addr);
        check({v.name, " s_wdata"}, slv.wdata, v.wdata);
        check({v.name, " s_wstrb"}, 32'(slv.wstrb), 32'(v.wstrb));
        check({v.name, " s_instr"}, 32'(slv.instr), 32'(v.instr));
      end
      if (cpu.ready) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check({v.name, " m_ready latency"}, 32'(lat), 32'(v.exp_lat));
    @(posedge clk); #1;
    cpu.valid = 1'b0;
    slv.ready = '0;
    @(negedge clk);
    check({v.name, " m_ready one cycle"}, 32'(cpu.ready), 32'h0);
  endtask

  // Scoreboard: every m_ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && cpu.ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected m_ready: got 1 want 0 (no transaction outstanding)");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, " m_rdata"},  cpu.rdata, e.rdata);
        check({e.name, " bus_err"},  32'(bus_err), 32'(e.err));
        check({e.name, " err_addr"}, err_addr, e.err_addr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    cpu.valid = 1'b0;
    cpu.instr = 1'b0;
    cpu.addr  = '0;
    cpu.wdata = '0;
    cpu.wstrb = '0;
    slv.ready = '0;
    slv.rdata = '0;

    vecs.push_back(mk("rd_s0_zero_wait", 32'h0000_0010, 32'h0, 4'b0000, 1'b0, 1'b1,
                      0, 32'h1234_5678, 4'b0001, 1, 1'b0, 32'h1234_5678, 2));
    vecs.push_back(mk("wr_s2_3_waits",   32'h0001_0004, 32'hA5A5_A5A5, 4'b0011, 1'b0, 1'b0,
                      3, 32'h0BAD_F00D, 4'b0100, 4, 1'b0, 32'h0BAD_F00D, 5));
    vecs.push_back(mk("rd_unmapped",     32'h8000_0000, 32'h0, 4'b0000, 1'b0, 1'b1,
                      0, 32'h1111_2222, 4'b0000, 0, 1'b1, 32'hDEAD_BEEF, 2));
    vecs.push_back(mk("rd_s1_1_wait",    32'h0002_0ABC, 32'h0, 4'b0000, 1'b0, 1'b1,
                      1, 32'hCAFE_0001, 4'b0010, 2, 1'b0, 32'hCAFE_0001, 3));
    vecs.push_back(mk("fetch_s3",        32'h0010_0100, 32'h0, 4'b0000, 1'b1, 1'b1,
                      0, 32'h0F0F_F0F0, 4'b1000, 1, 1'b0, 32'h0F0F_F0F0, 2));
    vecs.push_back(mk("wr_unmapped",     32'h0003_0000, 32'h7654_3210, 4'b1111, 1'b0, 1'b1,
                      0, 32'h3333_4444, 4'b0000, 0, 1'b1, 32'hDEAD_BEEF, 2));
    vecs.push_back(mk("wr_s0_top_word",  32'h0000_FFFC, 32'h0102_0304, 4'b1111, 1'b0, 1'b0,
                      2, 32'h5555_AAAA, 4'b0001, 3, 1'b0, 32'h5555_AAAA, 4));
`ifdef MEMBUS_TIMEOUT_EN
    vecs.push_back(mk("s3_timeout",      32'h0010_0000, 32'h0, 4'b0000, 1'b0, 1'b1,
                      100, 32'h9999_0000, 4'b1000, 8, 1'b1, 32'hDEAD_BEEF, 10));
    vecs.push_back(mk("s3_ready_at_expiry", 32'h0010_0040, 32'h0, 4'b0000, 1'b0, 1'b1,
                      7, 32'h7777_1111, 4'b1000, 8, 1'b0, 32'h7777_1111, 9));
`endif

    // Reset values while resetn is held low.
    #23;
    check("reset m_ready",  32'(cpu.ready), 32'h0);
    check("reset bus_err",  32'(bus_err),   32'h0);
    check("reset s_valid",  32'(slv.valid), 32'h0);
    check("reset s_instr",  32'(slv.instr), 32'h0);
    check("reset s_wstrb",  32'(slv.wstrb), 32'h0);
    check("reset m_rdata",  cpu.rdata, 32'h0);
    check("reset s_addr",   slv.addr,  32'h0);
    check("reset s_wdata",  slv.wdata, 32'h0);
    check("reset err_addr", err_addr,  32'h0);
    #4 resetn = 1'b1;

    // Overlapping decode: the default map also hits slave 0 for 0x0001_0004.
    @(posedge clk); #1;
    cpu.valid = 1'b1;
    cpu.addr  = 32'h0001_0004;
    cpu.wstrb = 4'b0000;
    slv.ready = '0;
    slv.rdata = {32'h3000_0ABC, 32'h2000_0ABC, 32'h1000_0ABC, 32'h0000_0ABC};
    sb_q.push_back('{"overlap", 32'h2000_0ABC, 1'b0, last_err_addr});
    @(posedge clk); #1;
    slv.ready = 4'b1111;
    @(negedge clk);
    check("overlap default-map s_valid", 32'(def_slv.valid), 32'h1);
    check("overlap bench-map s_valid",   32'(slv.valid),     32'h4);
    @(posedge clk); #1;
    cpu.valid = 1'b0;
    slv.ready = '0;
    @(negedge clk);
    check("overlap default-map m_ready", 32'(def_cpu.ready), 32'h1);
    check("overlap default-map m_rdata", def_cpu.rdata, 32'h0000_0ABC);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted while the router waits on slave 3.
    @(posedge clk); #1;
    cpu.valid = 1'b1;
    cpu.addr  = 32'h0010_0000;
    cpu.wstrb = 4'b0000;
    slv.ready = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid-reset s_valid before", 32'(slv.valid), 32'h8);
    #2 resetn = 1'b0;
    #1;
    check("mid-reset s_valid", 32'(slv.valid), 32'h0);
    check("mid-reset m_ready", 32'(cpu.ready), 32'h0);
    check("mid-reset s_addr",  slv.addr, 32'h0);
    check("mid-reset err_addr", err_addr, 32'h0);
    cpu.valid = 1'b0;
    last_err_addr = 32'h0;
    @(posedge clk); #1;
    resetn = 1'b1;

    // A fresh read after reset completes normally; err_addr stays at its reset value.
    run_vec(vecs[0]);
    check("err_addr sticky after reset", err_addr, 32'h0);

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
